serial_adder: RTL

Parametrised, multi-cycle add/subtract unit. It processes a WIDTH-bit operand pair DIGIT bits per clock through a registered carry. It is the sequential successor to the combinational half-adder cell, and the first adder in the design with a valid/ready handshake on both sides. It sits between operand producers and result consumers wherever area matters more than single-cycle latency.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/full_adder.sv | 31 +++
 rtl/half_adder.sv | 13 +
 rtl/serial_adder.sv | 117 +++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder shared types: FSM state encoding and step/counter sizing.
// Optional feature macro used by this block: SERIAL_ADDER_OVERFLOW_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit steps needed to cover the full operand width.
    function automatic int steps_f(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter width, never narrower than one bit.
    function automatic int cnt_w_f(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: two half_adders plus an OR for the carry.
// Chained DIGIT times inside serial_adder to form one digit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (w_s0),
        .c (w_c0)
    );

    half_adder u_ha1 (
        .a (w_s0),
        .b (cin),
        .s (s),
        .c (w_c1)
    );

    assign cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit sum and carry of two inputs.
// Building block of full_adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, DIGIT bits per clock, valid/ready on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STEPS = steps_f(WIDTH, DIGIT);
    localparam int CW    = cnt_w_f(STEPS);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_s;

    assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_count == CW'(STEPS - 1));
    assign w_c[0]   = r_carry;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
        full_adder u_fa (
            .a    (r_op_a[gi]),
            .b    (r_op_b[gi]),
            .cin  (w_c[gi]),
            .s    (w_s[gi]),
            .cout (w_c[gi+1])
        );
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: a DONE result consumed together with new operands goes straight to RUN.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = RUN;
            RUN:  if (w_last) w_next = DONE;
            DONE: if (out_ready) w_next = w_accept ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latch on accept, then one digit per RUN cycle shifted into sum from the top.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_op_a  <= r_op_a >> DIGIT;
            r_op_b  <= r_op_b >> DIGIT;
            r_sum   <= WIDTH'({w_s, r_sum} >> DIGIT);
            r_carry <= w_c[DIGIT];
            r_count <= r_count + CW'(1);
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it on the final step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= w_c[DIGIT-1] ^ w_c[DIGIT];
        end
    end

    assign overflow = r_ovf;
`endif

    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry;

endmodule
